// File: rtl/ball_engine_pkg.sv
// ============================================================================
// Module   : ball_engine_pkg
// Brief    : Pong geometry constants and ball engine state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ball_engine_pkg;

    localparam int SCREEN_H_RES  = 640;
    localparam int SCREEN_V_RES  = 480;
    localparam int X_POS_W       = 10;
    localparam int Y_POS_W       = 9;
    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_HEIGHT = 60;
    localparam int BALL_SIDE     = 10;

    // Signed width wide enough for any sprite edge sum without overflow.
    localparam int CMP_W = X_POS_W + 2;

    typedef enum logic [2:0] {
        SERVE  = 3'd0,
        WAIT   = 3'd1,
        MOVE   = 3'd2,
        BOUNCE = 3'd3,
        COMMIT = 3'd4
    } ball_state_t;

endpackage

`default_nettype wire

// File: rtl/ball_engine_paddle_hit_check.sv
// ============================================================================
// Module   : paddle_hit_check
// Brief    : Combinational ball/paddle collision test for one paddle side.
// Revision : 1.0
// ============================================================================
`default_nettype none

module paddle_hit_check
    import ball_engine_pkg::*;
#(
    parameter bit PADDLE_ON_LEFT = 1'b1
) (
    input  logic signed [CMP_W-1:0] i_ball_x,
    input  logic signed [CMP_W-1:0] i_ball_y,
    input  logic signed [CMP_W-1:0] i_paddle_x,
    input  logic signed [CMP_W-1:0] i_paddle_y,
    input  logic                    i_ball_left,
    output logic                    o_hit
);

    localparam logic signed [CMP_W-1:0] c_ball_side = CMP_W'(BALL_SIDE);
    localparam logic signed [CMP_W-1:0] c_pad_w     = CMP_W'(PADDLE_WIDTH);
    localparam logic signed [CMP_W-1:0] c_pad_h     = CMP_W'(PADDLE_HEIGHT);

    logic w_overlap;
    logic w_x_hit;

    assign w_overlap = ((i_ball_y + c_ball_side) > i_paddle_y) &&
                       (i_ball_y < (i_paddle_y + c_pad_h));

    // Only a ball travelling towards the paddle can hit it.
    generate
        if (PADDLE_ON_LEFT) begin : g_left
            assign w_x_hit = i_ball_left &&
                             (i_ball_x < (i_paddle_x + c_pad_w)) &&
                             ((i_ball_x + c_ball_side) > i_paddle_x);
        end else begin : g_right
            assign w_x_hit = !i_ball_left &&
                             ((i_ball_x + c_ball_side) > i_paddle_x) &&
                             (i_ball_x < (i_paddle_x + c_pad_w));
        end
    endgenerate

    assign o_hit = w_overlap && w_x_hit;

endmodule

`default_nettype wire

// File: rtl/ball_engine.sv
// ============================================================================
// Module   : ball_engine
// Brief    : Per-frame ball motion, collision resolution, serve and scoring.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int SPEED_X            = 2,
    parameter int SPEED_Y            = 2,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int SCORE_W            = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               new_frame_i,
    input  logic [X_POS_W-1:0] player_paddle_x_i,
    input  logic [Y_POS_W-1:0] player_paddle_y_i,
    input  logic [X_POS_W-1:0] pc_paddle_x_i,
    input  logic [Y_POS_W-1:0] pc_paddle_y_i,
    output logic [X_POS_W-1:0] ball_x_o,
    output logic [Y_POS_W-1:0] ball_y_o,
    output logic               ball_left_o,
    output logic               ball_up_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] pc_score_o,
    output logic               point_o,
    output logic               busy_o
);

    localparam int CNT_W = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;

    localparam logic [CNT_W-1:0]       c_cnt_last = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [X_POS_W-1:0]     c_cx       = X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2);
    localparam logic [Y_POS_W-1:0]     c_cy       = Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2);
    localparam logic signed [X_POS_W:0] c_speed_x = (X_POS_W + 1)'(SPEED_X);
    localparam logic signed [Y_POS_W:0] c_speed_y = (Y_POS_W + 1)'(SPEED_Y);
    localparam logic signed [X_POS_W:0] c_x_max   = (X_POS_W + 1)'(SCREEN_H_RES - BALL_SIDE);
    localparam logic signed [Y_POS_W:0] c_y_max   = (Y_POS_W + 1)'(SCREEN_V_RES - BALL_SIDE);
    localparam logic [Y_POS_W-1:0]     c_y_max_u  = Y_POS_W'(SCREEN_V_RES - BALL_SIDE);
    localparam logic [X_POS_W-1:0]     c_pad_w    = X_POS_W'(PADDLE_WIDTH);
    localparam logic [X_POS_W-1:0]     c_ball_w   = X_POS_W'(BALL_SIDE);

    ball_state_t r_state;
    ball_state_t w_state_next;

    logic [CNT_W-1:0]          r_serve_cnt;
    logic [X_POS_W-1:0]        r_x;
    logic [Y_POS_W-1:0]        r_y;
    logic                      r_left;
    logic                      r_up;
    logic signed [X_POS_W:0]   r_nx;
    logic signed [Y_POS_W:0]   r_ny;
    logic [SCORE_W-1:0]        r_player_score;
    logic [SCORE_W-1:0]        r_pc_score;
    logic                      r_point;
    logic                      r_busy;

    logic [Y_POS_W-1:0]        w_ny_res;
    logic                      w_up_next;
    logic signed [CMP_W-1:0]   w_nx_cmp;
    logic signed [CMP_W-1:0]   w_ny_cmp;
    logic                      w_hit_player;
    logic                      w_hit_pc;
    logic [X_POS_W-1:0]        w_nx_res;
    logic                      w_left_next;
    logic                      w_pt_player;
    logic                      w_pt_pc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SERVE:   if (new_frame_i && (r_serve_cnt == c_cnt_last)) w_state_next = WAIT;
            WAIT:    if (new_frame_i) w_state_next = MOVE;
            MOVE:    w_state_next = BOUNCE;
            BOUNCE:  w_state_next = COMMIT;
            COMMIT:  w_state_next = r_point ? SERVE : WAIT;
            default: w_state_next = SERVE;
        endcase
    end

    // Wall clamp first; paddle overlap is judged on the clamped row.
    always_comb begin
        w_ny_res  = r_ny[Y_POS_W-1:0];
        w_up_next = r_up;
        if (r_ny[Y_POS_W]) begin
            w_ny_res  = '0;
            w_up_next = 1'b0;
        end else if (r_ny > c_y_max) begin
            w_ny_res  = c_y_max_u;
            w_up_next = 1'b1;
        end
    end

    assign w_nx_cmp = {{(CMP_W - X_POS_W - 1){r_nx[X_POS_W]}}, r_nx};
    assign w_ny_cmp = $signed(CMP_W'(w_ny_res));

    paddle_hit_check #(
        .PADDLE_ON_LEFT (1'b1)
    ) u_player_hit (
        .i_ball_x    (w_nx_cmp),
        .i_ball_y    (w_ny_cmp),
        .i_paddle_x  ($signed(CMP_W'(player_paddle_x_i))),
        .i_paddle_y  ($signed(CMP_W'(player_paddle_y_i))),
        .i_ball_left (r_left),
        .o_hit       (w_hit_player)
    );

    paddle_hit_check #(
        .PADDLE_ON_LEFT (1'b0)
    ) u_pc_hit (
        .i_ball_x    (w_nx_cmp),
        .i_ball_y    (w_ny_cmp),
        .i_paddle_x  ($signed(CMP_W'(pc_paddle_x_i))),
        .i_paddle_y  ($signed(CMP_W'(pc_paddle_y_i))),
        .i_ball_left (r_left),
        .o_hit       (w_hit_pc)
    );

    // Paddle hits take priority; a miss is only scored when neither paddle hit.
    always_comb begin
        w_nx_res    = r_nx[X_POS_W-1:0];
        w_left_next = r_left;
        w_pt_player = 1'b0;
        w_pt_pc     = 1'b0;
        if (w_hit_player) begin
            w_nx_res    = player_paddle_x_i + c_pad_w;
            w_left_next = 1'b0;
        end else if (w_hit_pc) begin
            w_nx_res    = pc_paddle_x_i - c_ball_w;
            w_left_next = 1'b1;
        end else if (r_left && r_nx[X_POS_W]) begin
            w_pt_pc = 1'b1;
        end else if (!r_left && (r_nx > c_x_max)) begin
            w_pt_player = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_serve_cnt    <= '0;
            r_x            <= c_cx;
            r_y            <= c_cy;
            r_left         <= 1'b0;
            r_up           <= 1'b0;
            r_nx           <= '0;
            r_ny           <= '0;
            r_player_score <= '0;
            r_pc_score     <= '0;
            r_point        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                SERVE: begin
                    if (new_frame_i) begin
                        r_serve_cnt <= (r_serve_cnt == c_cnt_last) ? '0 : r_serve_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (new_frame_i) r_busy <= 1'b1;
                end
                MOVE: begin
                    r_nx <= r_left ? ($signed({1'b0, r_x}) - c_speed_x)
                                   : ($signed({1'b0, r_x}) + c_speed_x);
                    r_ny <= r_up   ? ($signed({1'b0, r_y}) - c_speed_y)
                                   : ($signed({1'b0, r_y}) + c_speed_y);
                end
                BOUNCE: begin
                    r_busy <= 1'b0;
                    if (w_pt_player || w_pt_pc) begin
                        r_x     <= c_cx;
                        r_y     <= c_cy;
                        r_left  <= w_pt_pc;
                        r_point <= 1'b1;
                        if (w_pt_player && (r_player_score != '1)) begin
                            r_player_score <= r_player_score + 1'b1;
                        end
                        if (w_pt_pc && (r_pc_score != '1)) begin
                            r_pc_score <= r_pc_score + 1'b1;
                        end
                    end else begin
                        r_x    <= w_nx_res;
                        r_y    <= w_ny_res;
                        r_left <= w_left_next;
                        r_up   <= w_up_next;
                    end
                end
                COMMIT: begin
                    r_point <= 1'b0;
                end
                default: begin
                    r_point <= 1'b0;
                end
            endcase
        end
    end

    assign ball_x_o       = r_x;
    assign ball_y_o       = r_y;
    assign ball_left_o    = r_left;
    assign ball_up_o      = r_up;
    assign player_score_o = r_player_score;
    assign pc_score_o     = r_pc_score;
    assign point_o        = r_point;
    assign busy_o         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ball_engine.sv
// ============================================================================
// Module   : tb_ball_engine
// Brief    : Randomized frame-level bench for ball_engine with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ball_engine;

    localparam int SDF   = 60;
    localparam int X_LIM = 630;
    localparam int Y_LIM = 470;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       new_frame;
    logic [9:0] pp_x, pc_x;
    logic [8:0] pp_y, pc_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_left, ball_up, point, busy;
    logic [3:0] player_score, pc_score;

    always #5 clk = ~clk;

    ball_engine #(
        .SPEED_X            (2),
        .SPEED_Y            (2),
        .SERVE_DELAY_FRAMES (SDF),
        .SCORE_W            (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .new_frame_i       (new_frame),
        .player_paddle_x_i (pp_x),
        .player_paddle_y_i (pp_y),
        .pc_paddle_x_i     (pc_x),
        .pc_paddle_y_i     (pc_y),
        .ball_x_o          (ball_x),
        .ball_y_o          (ball_y),
        .ball_left_o       (ball_left),
        .ball_up_o         (ball_up),
        .player_score_o    (player_score),
        .pc_score_o        (pc_score),
        .point_o           (point),
        .busy_o            (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the game: current state (m_*) and predicted next-frame state (e_*).
    int m_x, m_y, m_left, m_up, m_ps, m_cs, m_serve, m_cnt;
    int e_x, e_y, e_left, e_up, e_ps, e_cs, e_serve, e_cnt, e_pt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 315; m_y = 235; m_left = 0; m_up = 0;
        m_ps = 0; m_cs = 0; m_serve = 1; m_cnt = 0;
    endtask

    task automatic model_predict();
        int nx, ny, ppx, ppy, cpx, cpy;
        bit ovp, ovc;
        e_x = m_x; e_y = m_y; e_left = m_left; e_up = m_up;
        e_ps = m_ps; e_cs = m_cs; e_serve = m_serve; e_cnt = m_cnt; e_pt = 0;
        ppx = int'(pp_x); ppy = int'(pp_y); cpx = int'(pc_x); cpy = int'(pc_y);
        if (m_serve != 0) begin
            e_cnt = m_cnt + 1;
            if (e_cnt == SDF) begin
                e_cnt = 0;
                e_serve = 0;
            end
        end else begin
            nx = (m_left != 0) ? m_x - 2 : m_x + 2;
            ny = (m_up != 0) ? m_y - 2 : m_y + 2;
            if (ny < 0) begin
                ny = 0; e_up = 0;
            end else if (ny > Y_LIM) begin
                ny = Y_LIM; e_up = 1;
            end
            ovp = (ny + 10 > ppy) && (ny < ppy + 60);
            ovc = (ny + 10 > cpy) && (ny < cpy + 60);
            if (m_left != 0 && ovp && nx < ppx + 10 && nx + 10 > ppx) begin
                nx = ppx + 10; e_left = 0;
            end else if (m_left == 0 && ovc && nx + 10 > cpx && nx < cpx + 10) begin
                nx = cpx - 10; e_left = 1;
            end else if (m_left != 0 && nx < 0) begin
                e_pt = 2;
            end else if (m_left == 0 && nx > X_LIM) begin
                e_pt = 1;
            end
            if (e_pt != 0) begin
                if (e_pt == 1 && e_ps < 15) e_ps++;
                if (e_pt == 2 && e_cs < 15) e_cs++;
                e_x = 315; e_y = 235;
                e_left = (e_pt == 2) ? 1 : 0;
                e_up = m_up;
                e_serve = 1; e_cnt = 0;
            end else begin
                e_x = nx; e_y = ny;
            end
        end
    endtask

    task automatic model_commit();
        m_x = e_x; m_y = e_y; m_left = e_left; m_up = e_up;
        m_ps = e_ps; m_cs = e_cs; m_serve = e_serve; m_cnt = e_cnt;
    endtask

    task automatic check_outputs(input int exp_point);
        check("ball_x", int'(ball_x), m_x);
        check("ball_y", int'(ball_y), m_y);
        check("ball_left", int'(ball_left), m_left);
        check("ball_up", int'(ball_up), m_up);
        check("player_score", int'(player_score), m_ps);
        check("pc_score", int'(pc_score), m_cs);
        check("point", int'(point), exp_point);
        check("busy_idle", int'(busy), 0);
    endtask

    // spur: 0 none, 1/2/3 = extra pulse in MOVE/BOUNCE/COMMIT cycle (must be ignored).
    task automatic do_frame(input int spur_in, output int pt);
        int play, spur;
        model_predict();
        pt   = e_pt;
        play = (m_serve == 0) ? 1 : 0;
        spur = (play != 0) ? spur_in : 0;
        model_commit();
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = (spur == 1);
        check("busy_n1", int'(busy), play);
        @(posedge clk); #1 new_frame = (spur == 2);
        check("busy_n2", int'(busy), play);
        @(posedge clk); #1 new_frame = (spur == 3);
        check_outputs((pt != 0) ? 1 : 0);
        @(posedge clk); #1 new_frame = 1'b0;
        check("point_clear", int'(point), 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    function automatic int track(input int y);
        int t;
        t = y - 25;
        if (t < 0) t = 0;
        if (t > 420) t = 420;
        return t;
    endfunction

    function automatic int avoid(input int y);
        return (y >= 240) ? 0 : 400;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pt, pts, prev_x, prev_y, prev_left, prev_up, found;
        rst_ni = 1'b0; new_frame = 1'b0;
        pp_x = 10'd20; pp_y = '0; pc_x = 10'd610; pc_y = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
        check_outputs(0);

        // Serve hold then first move.
        for (int i = 0; i < SDF + 1; i++) begin
            pc_y = 9'(track(m_y));
            do_frame(0, pt);
        end
        check("t1_x", int'(ball_x), 317);
        check("t1_y", int'(ball_y), 237);

        // Long rally: both paddles track; bottom wall and right paddle bounces.
        for (int i = 0; i < 400; i++) begin
            prev_x = m_x; prev_y = m_y; prev_left = m_left; prev_up = m_up;
            pp_y = 9'(track(m_y));
            pc_y = 9'(track(m_y));
            do_frame($urandom_range(0, 3), pt);
            if (prev_y == 469 && prev_up == 0) begin
                check("t2_clamp_y", int'(ball_y), 470);
                check("t2_up", int'(ball_up), 1);
            end
            if (prev_x == 599 && prev_left == 0) begin
                check("t3_hit_x", int'(ball_x), 600);
                check("t3_left", int'(ball_left), 1);
            end
        end

        // Right-side misses until the player score saturates, plus one more.
        pts = 0;
        for (int i = 0; i < 8000 && pts < 16; i++) begin
            pp_y = 9'(track(m_y));
            pc_y = 9'(avoid(m_y));
            do_frame($urandom_range(0, 3), pt);
            if (pt != 0) pts++;
        end
        check("t4_points", pts, 16);
        check("t5_sat", int'(player_score), 15);

        // Random paddles: mixed hits and misses on both sides.
        for (int i = 0; i < 300; i++) begin
            pp_y = 9'($urandom_range(0, 420));
            pc_y = 9'($urandom_range(0, 420));
            do_frame($urandom_range(0, 3), pt);
        end

        // Reset asserted in the BOUNCE cycle of a scoring frame.
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            pp_y = 9'(track(m_y));
            pc_y = 9'(avoid(m_y));
            model_predict();
            if (e_pt != 0) begin
                found = 1;
            end else begin
                do_frame(0, pt);
            end
        end
        check("t6_found", found, 1);
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b1;
        model_reset();
        check_outputs(0);
        @(posedge clk); #1;
        check("t6_no_point", int'(point), 0);

        // Serve counter must restart from zero after the mid-update reset.
        for (int i = 0; i < SDF + 2; i++) begin
            pc_y = 9'(avoid(m_y));
            do_frame(0, pt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ball_engine.md
Name: ball_engine

Overview:
Game-state producer for the pong display path: owns ball position, direction, serve timing and scores.
Advances the ball once per frame on the display's new-frame pulse and resolves wall and paddle collisions.
Presents ball coordinates that the display samples on its next new-frame pulse.
Player paddle is on the left, computer paddle on the right. All coordinates are sprite top-left corners.

Parameters:
SPEED_X, 2, horizontal pixels moved per frame
SPEED_Y, 2, vertical pixels moved per frame
SERVE_DELAY_FRAMES, 60, frames the ball is held at centre before moving
SCORE_W, 4, width of each score counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset
new_frame_i  input  1  one-cycle pulse per frame from display
player_paddle_x_i  input  X_POS_W  left paddle x
player_paddle_y_i  input  Y_POS_W  left paddle y
pc_paddle_x_i  input  X_POS_W  right paddle x
pc_paddle_y_i  input  Y_POS_W  right paddle y
ball_x_o  output  X_POS_W  ball x
ball_y_o  output  Y_POS_W  ball y
ball_left_o  output  1  1 = moving left
ball_up_o  output  1  1 = moving up
player_score_o  output  SCORE_W  left score
pc_score_o  output  SCORE_W  right score
point_o  output  1  one-cycle pulse when a point is scored
busy_o  output  1  update in progress

Behaviour:
- Reset: one clock, synchronous, active-low (rst_ni = 0 resets on the clock edge).
- Reset values:
  - ball_x_o = CX = (SCREEN_H_RES-BALL_SIDE)/2; ball_y_o = CY = (SCREEN_V_RES-BALL_SIDE)/2.
  - ball_left_o = 0, ball_up_o = 0, scores = 0, point_o = 0, busy_o = 0.
  - State SERVE, serve counter = 0.
- States: SERVE, WAIT, MOVE, BOUNCE, COMMIT.
- SERVE: ball held at (CX,CY).
  - Each new_frame_i increments the serve counter.
  - A pulse seen while counter == SERVE_DELAY_FRAMES-1 clears the counter and enters WAIT.
  - With SERVE_DELAY_FRAMES=1, the first pulse enters WAIT.
- WAIT: new_frame_i enters MOVE and sets busy_o=1.
- MOVE (1 cycle): nx = x ± SPEED_X, ny = y ± SPEED_Y, sign from the direction bits. Computed in X_POS_W+1 / Y_POS_W+1 bit two's complement; MSB set means negative.
- BOUNCE (1 cycle): paddle inputs are sampled here.
  - Top wall: ny < 0 → ny = 0, up = 0.
  - Bottom wall: ny > SCREEN_V_RES-BALL_SIDE → ny = that limit, up = 1.
  - Vertical overlap with paddle P: ny+BALL_SIDE > P_y and ny < P_y+PADDLE_HEIGHT.
  - Left paddle hit: left=1, overlap, nx < player_x+PADDLE_WIDTH, nx+BALL_SIDE > player_x → nx = player_x+PADDLE_WIDTH, left = 0.
  - Right paddle hit: left=0, overlap, nx+BALL_SIDE > pc_x, nx < pc_x+PADDLE_WIDTH → nx = pc_x-BALL_SIDE, left = 1.
  - Miss: only evaluated when no paddle hit (paddle priority).
    - nx < 0 while moving left → pc point.
    - nx > SCREEN_H_RES-BALL_SIDE while moving right → player point.
  - A wall clamp and a paddle hit in the same frame are both applied.
- COMMIT (1 cycle): outputs registered.
  - No point: ball_x_o/ball_y_o = nx/ny, busy_o → 0, next state WAIT.
  - Point: scorer's counter +1, saturating at 2^SCORE_W-1. point_o = 1 for exactly one cycle. Ball set to (CX,CY). ball_left_o points toward the conceding side. ball_up_o unchanged. busy_o → 0. Next state SERVE.
- Latency: new_frame_i in cycle N → outputs valid in cycle N+3. new_frame_i during MOVE/BOUNCE/COMMIT is ignored.
- Reset mid-update: all state returns to reset values the next cycle. No point_o, no score change.
- Outputs are stable outside COMMIT.

Decomposition:
- Shared pong package (existing): SCREEN_H_RES, SCREEN_V_RES, X_POS_W, Y_POS_W, PADDLE_WIDTH, PADDLE_HEIGHT, BALL_SIDE.
- New in the package: ball_state_t enum (SERVE, WAIT, MOVE, BOUNCE, COMMIT).
- One sub-module, paddle_hit_check: combinational overlap test instanced once per paddle, with a PADDLE_ON_LEFT parameter.

Test Plan:
Bench values: 640x480 screen, BALL_SIDE 10, paddle 10x60, defaults except where noted.
1. rst_ni low 2 cycles → ball (315,235), scores 0. 60 frame pulses → no motion. 61st pulse → at N+3 ball (317,237), busy_o high N+1..N+2.
2. SERVE_DELAY_FRAMES=1, paddles clear of the ball path. Step until y=469; next frame → y clamps to 470, ball_up_o=1. Following frame → y=468.
3. pc_paddle_x_i=610, pc_paddle_y_i tracking ball_y-25. Ball reaches x=599; next frame → x=600, ball_left_o=1. Next → 598.
4. pc_paddle_y_i=0, no overlap with ball. From x=629, next frame → player_score_o=1, point_o high exactly 1 cycle, ball (315,235), state SERVE. Ball holds for SERVE_DELAY_FRAMES pulses.
5. player_score_o=15 (SCORE_W=4) and another right-side miss → score stays 15, point_o still pulses once.
6. Assert rst_ni=0 in the BOUNCE cycle of a scoring frame → next cycle all reset values, point_o never asserted.
